depth_stream_packer: RTL and testbench

DEPTH_STREAM_PACKER -- requirements
Module: depth_stream_packer

---
 rtl/dfdd_pkg.sv | 20 ++
 rtl/sync_stream_fifo.sv | 62 ++++++
 rtl/depth_stream_packer.sv | 139 +++++++++++++
 tb/tb_depth_stream_packer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfdd_pkg.sv
// Shared types for the depth/confidence stream path: pixel record layout,
// the FP16 field width and the packer FSM state encoding.
package dfdd_pkg;

    localparam int FP16_W = 16;

    // Field order matches the FIFO word: {user, last, c, z}.
    typedef struct packed {
        logic              user;
        logic              last;
        logic [FP16_W-1:0] c;
        logic [FP16_W-1:0] z;
    } pixel_t;

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_STREAM   = 1'b1
    } pack_state_e;

endpackage

// File: rtl/sync_stream_fifo.sv
// Single-clock stream FIFO with valid/ready output. Push into a full FIFO is
// refused unless a pop happens on the same edge; no push-to-pop bypass.
module sync_stream_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    // Handshake: a word leaves on any rising edge where valid_o && ready_i;
    // data_o holds while valid_o && !ready_i.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             pop;
    logic             wr_en;

    assign valid_o = (wr_ptr_q != rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = valid_o && ready_i;
    assign wr_en   = push_i && (!full_o || pop);
    assign data_o  = valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: data_o is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/depth_stream_packer.sv
// Packs the per-pixel depth/confidence stream into a framed valid/ready
// stream, enforcing raster order and flagging sequence and overflow errors.
module depth_stream_packer
    import dfdd_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 400,
    parameter int FP_WIDTH     = FP16_W,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [FP_WIDTH-1:0]   z_i,
    input  logic [FP_WIDTH-1:0]   c_i,
    input  logic [15:0]           col_i,
    input  logic [15:0]           row_i,
    input  logic                  valid_i,
    output logic [2*FP_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_user_o,
    output logic                  m_last_o,
    output logic                  frame_done_o,
    output logic                  overflow_o,
    output logic                  seq_err_o,
    output logic [15:0]           drop_count_o,
    output logic                  dbg_state_o
);

    localparam int          PIX_W    = 2 * FP_WIDTH + 2;
    localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

    pack_state_e       state_q, state_d;
    logic [15:0]       exp_col_q, exp_col_d;
    logic [15:0]       exp_row_q, exp_row_d;
    logic              push_q;
    logic [PIX_W-1:0]  push_data_q;
    logic              frame_done_q;
    logic              overflow_q;
    logic              seq_err_q;
    logic [15:0]       drop_count_q;

    logic              is_sof, is_exp, is_eol, is_eof;
    logic              accept, mismatch;
    logic              fifo_full, fifo_drop;
    logic [PIX_W-1:0]  fifo_rd_data;

    always_comb begin
        is_sof   = (col_i == 16'd0) && (row_i == 16'd0);
        is_exp   = (col_i == exp_col_q) && (row_i == exp_row_q);
        is_eol   = (col_i == LAST_COL);
        is_eof   = is_eol && (row_i == LAST_ROW);
        mismatch = valid_i && (state_q == ST_STREAM) && !is_exp;
        // A stray (0,0) mid-frame restarts the frame rather than being lost.
        accept   = valid_i && ((state_q == ST_WAIT_SOF) ? is_sof : (is_exp || is_sof));

        state_d   = state_q;
        exp_col_d = exp_col_q;
        exp_row_d = exp_row_q;
        if (accept) begin
            if (is_eof) begin
                state_d   = ST_WAIT_SOF;
                exp_col_d = '0;
                exp_row_d = '0;
            end else begin
                state_d = ST_STREAM;
                if (is_eol) begin
                    exp_col_d = '0;
                    exp_row_d = row_i + 16'd1;
                end else begin
                    exp_col_d = col_i + 16'd1;
                    exp_row_d = row_i;
                end
            end
        end else if (mismatch) begin
            state_d = ST_WAIT_SOF;
        end
    end

    // Dropped pixels still advance the FSM; only the FIFO write is lost.
    assign fifo_drop = push_q && fifo_full && !(m_valid_o && m_ready_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_WAIT_SOF;
            exp_col_q    <= '0;
            exp_row_q    <= '0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            seq_err_q    <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            exp_col_q    <= exp_col_d;
            exp_row_q    <= exp_row_d;
            push_q       <= accept;
            frame_done_q <= accept && is_eof;
            if (accept) begin
                push_data_q <= {is_sof, is_eol, c_i, z_i};
            end
            if (mismatch) begin
                seq_err_q <= 1'b1;
            end
            if (fifo_drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_q <= drop_count_q + 16'd1;
                end
            end
        end
    end

    sync_stream_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (push_q),
        .push_data_i (push_data_q),
        .full_o      (fifo_full),
        .valid_o     (m_valid_o),
        .ready_i     (m_ready_i),
        .data_o      (fifo_rd_data)
    );

    assign m_data_o     = fifo_rd_data[2*FP_WIDTH-1:0];
    assign m_last_o     = fifo_rd_data[PIX_W-2];
    assign m_user_o     = fifo_rd_data[PIX_W-1];
    assign frame_done_o = frame_done_q;
    assign overflow_o   = overflow_q;
    assign seq_err_o    = seq_err_q;
    assign drop_count_o = drop_count_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_depth_stream_packer.sv
// Directed bench for depth_stream_packer on a small 8x4 frame, with a
// queue-based reference model checked against the outputs every cycle.
module tb_depth_stream_packer;

    localparam int W = 8;
    localparam int H = 4;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] z_i, c_i, col_i, row_i;
    logic        valid_i;
    logic [31:0] m_data_o;
    logic        m_valid_o, m_ready_i, m_user_o, m_last_o;
    logic        frame_done_o, overflow_o, seq_err_o, dbg_state_o;
    logic [15:0] drop_count_o;

    depth_stream_packer #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .FP_WIDTH    (16),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .z_i         (z_i),
        .c_i         (c_i),
        .col_i       (col_i),
        .row_i       (row_i),
        .valid_i     (valid_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_user_o    (m_user_o),
        .m_last_o    (m_last_o),
        .frame_done_o(frame_done_o),
        .overflow_o  (overflow_o),
        .seq_err_o   (seq_err_o),
        .drop_count_o(drop_count_o),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position, expected output queue, 1-cycle pending push.
    logic [33:0] exp_q[$];
    bit          pend;
    logic [33:0] pend_w;
    bit          in_frame;
    int          ecol, erow;
    bit          m_fd, m_ovf, m_seq;
    int          m_drops;

    int          beats = 0, lasts = 0, users = 0, fds = 0;
    logic [33:0] last_beat;
    bit          prev_stall;
    logic [33:0] prev_word;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", 64'(m_valid_o), 64'd0);
            chk("rst_user_last", 64'({m_user_o, m_last_o}), 64'd0);
            chk("rst_data", 64'(m_data_o), 64'd0);
            chk("rst_flags", 64'({frame_done_o, overflow_o, seq_err_o}), 64'd0);
            chk("rst_drops", 64'(drop_count_o), 64'd0);
            exp_q.delete();
            pend = 0; in_frame = 0; ecol = 0; erow = 0;
            m_fd = 0; m_ovf = 0; m_seq = 0; m_drops = 0;
            prev_stall = 0;
        end else begin
            bit pop, was_full, sof, acc;
            chk("m_valid", 64'(m_valid_o), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                chk("beat", 64'({m_user_o, m_last_o, m_data_o}), 64'(exp_q[0]));
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid_o), 64'd1);
                chk("stall_hold", 64'({m_user_o, m_last_o, m_data_o}), 64'(prev_word));
            end
            chk("frame_done", 64'(frame_done_o), 64'(m_fd));
            chk("overflow", 64'(overflow_o), 64'(m_ovf));
            chk("seq_err", 64'(seq_err_o), 64'(m_seq));
            chk("drop_count", 64'(drop_count_o), 64'(m_drops));

            prev_stall = m_valid_o && !m_ready_i;
            prev_word  = {m_user_o, m_last_o, m_data_o};
            if (m_valid_o && m_ready_i) begin
                beats++;
                if (m_last_o) lasts++;
                if (m_user_o) users++;
                last_beat = {m_user_o, m_last_o, m_data_o};
            end
            if (frame_done_o) fds++;

            // Advance the model to the state after the coming rising edge.
            was_full = (exp_q.size() == D);
            pop      = (exp_q.size() != 0) && m_ready_i;
            if (pop) void'(exp_q.pop_front());
            if (pend) begin
                if (was_full && !pop) begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end else begin
                    exp_q.push_back(pend_w);
                end
            end
            pend = 0;
            m_fd = 0;
            if (valid_i) begin
                sof = (col_i == 0) && (row_i == 0);
                acc = 0;
                if (!in_frame) begin
                    acc = sof;
                end else begin
                    acc = sof || (int'(col_i) == ecol && int'(row_i) == erow);
                    if (!(int'(col_i) == ecol && int'(row_i) == erow)) begin
                        m_seq = 1;
                        in_frame = 0;
                    end
                end
                if (acc) begin
                    pend   = 1;
                    pend_w = {sof, int'(col_i) == W - 1, c_i, z_i};
                    if (int'(col_i) == W - 1 && int'(row_i) == H - 1) begin
                        m_fd = 1;
                        in_frame = 0;
                    end else begin
                        in_frame = 1;
                        ecol = (int'(col_i) == W - 1) ? 0 : int'(col_i) + 1;
                        erow = (int'(col_i) == W - 1) ? int'(row_i) + 1 : int'(row_i);
                    end
                end
            end
        end
    end

    int c_tag = 1;
    bit rand_ready = 0;

    task automatic send_pix(input int col, input int row);
        if (rand_ready) m_ready_i = 1'($urandom_range(0, 1));
        col_i   = 16'(col);
        row_i   = 16'(row);
        z_i     = {8'(row), 8'(col)};
        c_i     = 16'(c_tag);
        c_tag++;
        valid_i = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_ready) m_ready_i = 1'($urandom_range(0, 1));
            valid_i = 1'b0;
            @(posedge clk); #2;
        end
    endtask

    // Send raster pixels first..first+count-1, optionally with idle gaps.
    task automatic send_range(input int first, input int count, input bit gaps);
        for (int k = first; k < first + count; k++) begin
            send_pix(k % W, k / W);
            if (gaps) idle(1);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, f0, tag;
        rst_n = 1'b1; valid_i = 1'b0; m_ready_i = 1'b1;
        z_i = '0; c_i = '0; col_i = '0; row_i = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(2);
        chk("post_reset_valid", 64'(m_valid_o), 64'd0);

        // Full frame at ready=1.
        b0 = beats; f0 = fds;
        send_range(0, W * H, 1'b0);
        idle(6);
        chk("frame_beats", 64'(beats - b0), 64'd32);
        chk("frame_lasts", 64'(lasts), 64'd4);
        chk("frame_users", 64'(users), 64'd1);
        chk("frame_done_cnt", 64'(fds - f0), 64'd1);
        chk("frame_no_err", 64'({overflow_o, seq_err_o}), 64'd0);

        // Non-SOF pixels while waiting for SOF are silently discarded.
        b0 = beats;
        send_pix(3, 1);
        send_pix(7, 3);
        idle(4);
        chk("wait_sof_discard", 64'(beats - b0), 64'd0);
        chk("wait_sof_no_err", 64'(seq_err_o), 64'd0);

        // Stall with continuous input: 16 buffered, 4 dropped.
        m_ready_i = 1'b0;
        b0 = beats; f0 = fds;
        send_range(0, 20, 1'b0);
        idle(4);
        chk("ovf_drops", 64'(drop_count_o), 64'd4);
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        chk("ovf_no_beats", 64'(beats - b0), 64'd0);
        m_ready_i = 1'b1;
        idle(20);
        chk("ovf_drained", 64'(beats - b0), 64'd16);
        send_range(20, 12, 1'b0);
        idle(6);
        chk("ovf_frame_done", 64'(fds - f0), 64'd1);
        chk("ovf_tail_beats", 64'(beats - b0), 64'd28);

        // Fill FIFO, then push and pop on the same edge: nothing dropped.
        m_ready_i = 1'b0;
        b0 = beats;
        send_range(0, 17, 1'b0);
        m_ready_i = 1'b1;
        send_range(17, 15, 1'b0);
        idle(20);
        chk("full_pushpop_drops", 64'(drop_count_o), 64'd4);
        chk("full_pushpop_beats", 64'(beats - b0), 64'd32);

        // Sequence error: (5,0) after (2,0), then restart from (0,0).
        b0 = beats;
        send_pix(0, 0); send_pix(1, 0); send_pix(2, 0);
        send_pix(5, 0); send_pix(6, 0);
        tag = c_tag;
        send_pix(0, 0);
        idle(6);
        chk("seq_err_flag", 64'(seq_err_o), 64'd1);
        chk("seq_beats", 64'(beats - b0), 64'd4);
        chk("seq_sof_beat", 64'(last_beat), 64'({1'b1, 1'b0, 16'(tag), 16'h0000}));
        // Stray (0,0) while streaming becomes a new SOF.
        tag = c_tag;
        send_pix(0, 0);
        idle(4);
        chk("resof_beats", 64'(beats - b0), 64'd5);
        chk("resof_beat", 64'(last_beat), 64'({1'b1, 1'b0, 16'(tag), 16'h0000}));

        // Reset mid-frame with data buffered.
        m_ready_i = 1'b0;
        send_range(1, 21, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_now_valid", 64'(m_valid_o), 64'd0);
        chk("rst_now_flags", 64'({overflow_o, seq_err_o, drop_count_o}), 64'd0);
        valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Clean frame after reset with random backpressure.
        b0 = beats; f0 = fds;
        rand_ready = 1;
        send_range(0, W * H, 1'b1);
        rand_ready = 0;
        m_ready_i = 1'b1;
        idle(30);
        chk("rand_beats_plus_drops", 64'(beats - b0 + int'(drop_count_o)), 64'd32);
        chk("rand_frame_done", 64'(fds - f0), 64'd1);
        chk("rand_no_seq_err", 64'(seq_err_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
